// File: rtl/pdmafifo_read_ctrl.sv
// pdmafifo_read_ctrl
//   Read-side controller for the PDMA FIFO RAM. It owns the read pointer and
//   compares it with the write pointer. It issues read address and enable to a
//   pipelined RAM that has RD_LAT cycles of read latency. Returned words go into
//   a small circular skid buffer, which drives a valid/ready stream. The read
//   pointer, including its wrap bit, is handed back so the writer can compute
//   full.
//
// Ports
//   clk         single clock for the block
//   rst_n       asynchronous active-low reset
//   wptr        write pointer with wrap bit (AWIDTH+1), clk-synchronous
//   flush       one-cycle flush: drops unread, in-flight and buffered data
//   ren         RAM read enable
//   raddr       RAM read address (AWIDTH)
//   rdata       RAM read data, valid RD_LAT cycles after ren
//   rptr        read pointer with wrap bit (AWIDTH+1), to the write side
//   dout        stream data (head of the skid buffer)
//   dout_valid  dout holds a word
//   dout_ready  consumer accepts dout this cycle
//   empty       nothing left in RAM, in flight or buffered
module pdmafifo_read_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 7,
  parameter int RD_LAT  = 2,
  parameter int BUF_DEP = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH:0]   wptr,
  input  logic              flush,
  output logic              ren,
  output logic [AWIDTH-1:0] raddr,
  input  logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH:0]   rptr,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty
);

  localparam int CW = $clog2(BUF_DEP + 1);
  localparam int IW = (BUF_DEP > 1) ? $clog2(BUF_DEP) : 1;
  localparam int OW = $clog2(BUF_DEP + RD_LAT + 1) + 1;

  logic [AWIDTH:0]   rptr_reg;
  logic [RD_LAT-1:0] vpipe_reg;
  logic [RD_LAT-1:0] vpipe_next;
  logic [IW-1:0]     head_reg;
  logic [IW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;
  logic [DWIDTH-1:0] buf_mem [BUF_DEP];

  logic          ram_empty;
  logic          push;
  logic          pop;
  logic [OW-1:0] inflight;
  logic [OW-1:0] occ;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(BUF_DEP - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign ram_empty  = (rptr_reg == wptr);
  assign raddr      = rptr_reg[AWIDTH-1:0];
  assign rptr       = rptr_reg;
  assign dout_valid = (count_reg != '0);
  // Hold dout at zero while nothing is buffered so reset and idle look clean.
  assign dout       = dout_valid ? buf_mem[head_reg] : '0;
  assign pop        = dout_valid & dout_ready;
  // The tail of the valid pipe marks the cycle in which rdata belongs to us.
  assign push       = vpipe_reg[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OW'(vpipe_reg[i]);
    end
  end

  assign occ = inflight + OW'(count_reg);

  // Credit check: every issued read has a guaranteed buffer slot. A pop in
  // the same cycle frees one slot, so streaming continues at full rate.
  assign ren   = !ram_empty && !flush && ((occ - OW'(pop)) < OW'(BUF_DEP));
  assign empty = ram_empty && (occ == '0);

  always_comb begin
    vpipe_next    = vpipe_reg << 1;
    vpipe_next[0] = ren;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_reg  <= '0;
      vpipe_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      // Jump over all unread data. Any rdata still in the RAM pipeline is
      // ignored because its valid marker is cleared here.
      rptr_reg  <= wptr;
      vpipe_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (ren) begin
        rptr_reg <= rptr_reg + (AWIDTH+1)'(1);
      end
      vpipe_reg <= vpipe_next;
      if (push) begin
        tail_reg <= next_idx(tail_reg);
      end
      if (pop) begin
        head_reg <= next_idx(head_reg);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage has no reset. dout is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      buf_mem[tail_reg] <= rdata;
    end
  end

endmodule

// File: tb/tb_pdmafifo_read_ctrl.sv
// tb_pdmafifo_read_ctrl
//   Directed bench for pdmafifo_read_ctrl with a 2-cycle pipelined RAM model.
//   A scoreboard checks that words are popped in address order. Other checks
//   cover data held stable during stalls and occupancy never exceeding the
//   buffer depth.
module tb_pdmafifo_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wptr;
  logic        flush;
  logic        ren;
  logic [6:0]  raddr;
  logic [31:0] rdata;
  logic [7:0]  rptr;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        empty;

  logic [31:0] ram [128];
  logic [31:0] stage1;

  int checks = 0;
  int errors = 0;
  int occ_m, ren_cnt, pop_cnt, cyc, first_pop, last_pop;
  logic [7:0]  exp_addr;
  logic        stall_prev;
  logic [31:0] prev_dout;
  logic [6:0]  raddr_log [8];

  pdmafifo_read_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wptr       (wptr),
    .flush      (flush),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .rptr       (rptr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Pipelined RAM: address captured on the ren edge, data one edge later.
  always @(posedge clk) begin
    if (ren) stage1 <= ram[raddr];
    rdata <= stage1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_stats();
    ren_cnt   = 0;
    pop_cnt   = 0;
    first_pop = 0;
    last_pop  = 0;
  endtask

  // One clock cycle: sample at the falling edge, then return just after the
  // next rising edge so the caller can change inputs.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      chk("hold_valid", dout_valid, 1);
      chk("hold_dout", dout, prev_dout);
    end
    if (dout_valid && dout_ready) begin
      chk("data", dout, ram[exp_addr[6:0]]);
      $display("pop addr=%0d data=0x%08h", exp_addr, dout);
      exp_addr++;
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (ren) begin
      if (ren_cnt < 8) raddr_log[ren_cnt] = raddr;
      ren_cnt++;
    end
    if (flush || !rst_n) occ_m = 0;
    else occ_m += int'(ren) - int'(dout_valid && dout_ready);
    chk("occ_bound", occ_m <= 3, 1);
    stall_prev = dout_valid && !dout_ready && !flush && rst_n;
    prev_dout  = dout;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
    rst_n = 1'b0; wptr = 8'd0; flush = 1'b0; dout_ready = 1'b1;
    occ_m = 0; exp_addr = 8'd0; stall_prev = 1'b0; prev_dout = '0; cyc = 0;
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rptr", rptr, 0);
    chk("rst_ren", ren, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_empty", empty, 1);
    rst_n = 1'b1;

    // 1: single word, DOUT_VALID in cycle 3, EMPTY again in cycle 4
    wptr = 8'd1;
    #1;
    chk("t1_ren", ren, 1);
    chk("t1_raddr", raddr, 0);
    chk("t1_empty", empty, 0);
    cycle();
    chk("t1_c1_ren", ren, 0);
    chk("t1_c1_rptr", rptr, 1);
    chk("t1_c1_valid", dout_valid, 0);
    cycle();
    chk("t1_c2_valid", dout_valid, 0);
    cycle();
    chk("t1_c3_valid", dout_valid, 1);
    chk("t1_c3_dout", dout, ram[0]);
    chk("t1_c3_empty", empty, 0);
    cycle();
    chk("t1_c4_empty", empty, 1);
    chk("t1_c4_valid", dout_valid, 0);
    chk("t1_pops", pop_cnt, 1);

    // 2: 64-word burst at full rate
    clear_stats();
    wptr = 8'd65;
    for (int i = 0; i < 200 && exp_addr != 8'd65; i++) cycle();
    chk("t2_done", exp_addr, 65);
    chk("t2_ren_cnt", ren_cnt, 64);
    chk("t2_pops", pop_cnt, 64);
    chk("t2_no_gap", last_pop - first_pop + 1, 64);
    chk("t2_empty", empty, 1);
    chk("t2_rptr", rptr, 65);

    // 3: backpressure, ready pattern 1,0,0,1
    clear_stats();
    wptr = 8'd75;
    for (int i = 0; i < 200 && exp_addr != 8'd75; i++) begin
      dout_ready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    dout_ready = 1'b1;
    chk("t3_done", exp_addr, 75);
    chk("t3_pops", pop_cnt, 10);
    chk("t3_ren_cnt", ren_cnt, 10);
    chk("t3_empty", empty, 1);

    // 4: wrap through the top of the RAM
    wptr = 8'd126; flush = 1'b1;
    #1;
    chk("t4_flush_ren", ren, 0);
    cycle();
    flush = 1'b0; exp_addr = 8'd126;
    chk("t4_rptr0", rptr, 126);
    chk("t4_empty0", empty, 1);
    clear_stats();
    wptr = 8'd130;
    for (int i = 0; i < 100 && exp_addr != 8'd130; i++) cycle();
    chk("t4_done", exp_addr, 130);
    chk("t4_raddr0", raddr_log[0], 126);
    chk("t4_raddr1", raddr_log[1], 127);
    chk("t4_raddr2", raddr_log[2], 0);
    chk("t4_raddr3", raddr_log[3], 1);
    chk("t4_ren_cnt", ren_cnt, 4);
    chk("t4_rptr", rptr, 130);
    chk("t4_empty", empty, 1);

    // 5: flush with 2 reads in flight and 1 word buffered, coinciding with a pop
    clear_stats();
    dout_ready = 1'b0; wptr = 8'd140;
    repeat (3) cycle();
    chk("t5_rptr_pre", rptr, 133);
    chk("t5_valid_pre", dout_valid, 1);
    chk("t5_dout_pre", dout, ram[2]);
    dout_ready = 1'b1; flush = 1'b1;
    #1;
    chk("t5_flush_ren", ren, 0);
    cycle();
    flush = 1'b0; exp_addr = 8'd140;
    chk("t5_valid_post", dout_valid, 0);
    chk("t5_rptr_post", rptr, 140);
    chk("t5_empty_post", empty, 1);
    repeat (10) cycle();
    chk("t5_pops", pop_cnt, 1);
    chk("t5_ren_cnt", ren_cnt, 3);
    chk("t5_quiet", dout_valid, 0);

    // 6: asynchronous reset mid-burst
    clear_stats();
    wptr = 8'd180;
    repeat (10) cycle();
    chk("t6_busy", dout_valid, 1);
    #2;
    rst_n = 1'b0; wptr = 8'd0;
    #1;
    chk("t6_valid", dout_valid, 0);
    chk("t6_ren", ren, 0);
    chk("t6_rptr", rptr, 0);
    chk("t6_empty", empty, 1);
    chk("t6_dout", dout, 0);
    occ_m = 0; exp_addr = 8'd0; stall_prev = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_stats();
    repeat (10) cycle();
    chk("t6_idle_ren", ren_cnt, 0);
    chk("t6_idle_pops", pop_cnt, 0);
    chk("t6_idle_empty", empty, 1);
    chk("t6_idle_rptr", rptr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
